// File: rtl/tm_lif_sweep_ctrl.sv
// tm_lif_sweep_ctrl: sequencer for the time-multiplexed LIF datapath and its
// membrane-voltage DPRAM. Each timestep it reads neurons 0..N, writes each
// one back PIPE_LAT cycles later, and queues spiking neuron indices in an
// AER FIFO. On request it writes Vrst to neurons 0..N instead.
//
// Ports:
//   clk_in, reset_n          clock (rising edge), async active-low reset
//   tick, init_req, n_last   timestep start, clear request, last neuron index
//   rd_en, rd_addr           DPRAM read port
//   wr_en, wr_addr, wr_init  DPRAM write port; wr_init selects Vrst data
//   lif_spike                datapath spike, aligned with the sweep write
//   aer_valid/addr/ready     FWFT spike FIFO head and pop handshake
//   busy, step_done          FSM not idle, end-of-sweep pulse
//   tick_missed, aer_ovf     sticky error flags, cleared on entry to INIT
module tm_lif_sweep_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PIPE_LAT = 5,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              init_req,
  input  logic [ADDR_W-1:0] n_last,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_init,
  input  logic              lif_spike,
  output logic              aer_valid,
  output logic [ADDR_W-1:0] aer_addr,
  input  logic              aer_ready,
  output logic              busy,
  output logic              step_done,
  output logic              tick_missed,
  output logic              aer_ovf
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  typedef enum logic [1:0] {StIdle, StInit, StSweep, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic              pend_q, pend_d;
  logic              tick_missed_q, tick_missed_d;
  logic              aer_ovf_q, aer_ovf_d;
  logic              enter_init;

  // Read strobe/address delay line feeding the sweep write-back.
  logic [PIPE_LAT-1:0] dl_en_q;
  logic [ADDR_W-1:0]   dl_addr_q [PIPE_LAT];
  logic                sweep_wr;
  logic                drain_done;

  logic [ADDR_W-1:0] fifo_mem_q [Depth];
  logic [FIFO_AW:0]  wptr_q, rptr_q;
  logic              fifo_empty, fifo_full, push, pop, push_ok;

  assign sweep_wr   = dl_en_q[PIPE_LAT-1];
  assign drain_done = (state_q == StDrain) && (dl_en_q == '0);

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  // Next-state logic. A pending or coincident init request is taken straight
  // from the end of DRAIN so INIT follows step_done without an idle cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    enter_init = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (init_req || pend_q) begin
          state_d    = StInit;
          n_d        = n_last;
          cnt_d      = '0;
          enter_init = 1'b1;
        end else if (tick) begin
          state_d = StSweep;
          n_d     = n_last;
          cnt_d   = '0;
        end
      end
      StInit, StSweep: begin
        if (cnt_q == n_q) begin
          state_d = (state_q == StInit) ? StIdle : StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_done) begin
          if (init_req || pend_q) begin
            state_d    = StInit;
            n_d        = n_last;
            cnt_d      = '0;
            enter_init = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_init   = 1'b0;
    busy      = (state_q != StIdle);
    step_done = drain_done;
    if (state_q == StSweep) begin
      rd_en   = 1'b1;
      rd_addr = cnt_q;
    end
    if (state_q == StInit) begin
      wr_en   = 1'b1;
      wr_init = 1'b1;
      wr_addr = cnt_q;
    end else if (sweep_wr) begin
      wr_en   = 1'b1;
      wr_addr = dl_addr_q[PIPE_LAT-1];
    end
  end

  // Sticky flags and pending init. A tick that loses to an init in the same
  // cycle is still reported, so it overrides the clear on INIT entry.
  always_comb begin
    pend_d        = pend_q;
    tick_missed_d = tick_missed_q;
    aer_ovf_d     = aer_ovf_q;
    if (enter_init) begin
      pend_d        = 1'b0;
      tick_missed_d = tick;
      aer_ovf_d     = 1'b0;
    end else begin
      if (init_req && (state_q == StSweep || state_q == StDrain)) pend_d = 1'b1;
      if (tick && state_q != StIdle) tick_missed_d = 1'b1;
      if (push && !push_ok) aer_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pend_q        <= 1'b0;
      tick_missed_q <= 1'b0;
      aer_ovf_q     <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      tick_missed_q <= tick_missed_d;
      aer_ovf_q     <= aer_ovf_d;
    end
  end

  assign tick_missed = tick_missed_q;
  assign aer_ovf     = aer_ovf_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      dl_en_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dl_addr_q[i] <= '0;
    end else begin
      dl_en_q      <= {dl_en_q[PIPE_LAT-2:0], rd_en};
      dl_addr_q[0] <= rd_addr;
      for (int i = 1; i < PIPE_LAT; i++) dl_addr_q[i] <= dl_addr_q[i-1];
    end
  end

  // AER FIFO: extra pointer MSB separates full from empty.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign push       = sweep_wr && lif_spike;
  assign pop        = !fifo_empty && aer_ready;
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (enter_init) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem_q[wptr_q[FIFO_AW-1:0]] <= wr_addr;
  end

  assign aer_valid = !fifo_empty;
  // Gate the head so unwritten storage never reaches the port.
  assign aer_addr  = aer_valid ? fifo_mem_q[rptr_q[FIFO_AW-1:0]] : '0;

endmodule

// File: tb/tb_tm_lif_sweep_ctrl.sv
module tb_tm_lif_sweep_ctrl;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       init_req = 1'b0;
  logic [9:0] n_last = '0;
  logic       lif_spike = 1'b0;
  logic       aer_ready = 1'b0;
  logic       rd_en, wr_en, wr_init, aer_valid, busy, step_done, tick_missed, aer_ovf;
  logic [9:0] rd_addr, wr_addr, aer_addr;

  int n_err = 0;
  int n_chk = 0;

  tm_lif_sweep_ctrl dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .tick       (tick),
    .init_req   (init_req),
    .n_last     (n_last),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_init    (wr_init),
    .lif_spike  (lif_spike),
    .aer_valid  (aer_valid),
    .aer_addr   (aer_addr),
    .aer_ready  (aer_ready),
    .busy       (busy),
    .step_done  (step_done),
    .tick_missed(tick_missed),
    .aer_ovf    (aer_ovf)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       tick, init, spike, ready;
    logic [9:0] n;
    logic [37:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [37:0] pk();
    return {rd_en, rd_addr, wr_en, wr_addr, wr_init, busy, step_done,
            aer_valid, aer_addr, tick_missed, aer_ovf};
  endfunction

  function automatic vec_t mk(bit t, bit ini, int n, bit sp, bit rdy, bit re, int ra,
                              bit we, int wa, bit wi, bit bs, bit sd, bit av, int aa);
    vec_t v;
    v.tick  = t;
    v.init  = ini;
    v.n     = 10'(n);
    v.spike = sp;
    v.ready = rdy;
    v.exp   = {re, 10'(ra), we, 10'(wa), wi, bs, sd, av, 10'(aa), 1'b0, 1'b0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_in);
      if (step_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_done"}, 64'(seen), 64'd1);
  endtask

  // Sweep of neurons 0..19, every write spiking, consumer stalled.
  task automatic fill(input string nm);
    @(negedge clk_in);
    tick = 1'b1; n_last = 10'd19; lif_spike = 1'b1; aer_ready = 1'b0;
    @(negedge clk_in);
    tick = 1'b0;
    wait_done(nm);
    lif_spike = 1'b0;
  endtask

  initial begin
    int rd_cnt, sd_cnt;
    int pops[$];

    // Table: init of 0..7, then a sweep of 0..3 with one spike on neuron 1.
    tbl.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, i, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 3, 0, 0, 1, i, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 3, 0, 0, 0, 0, 1, 3, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(negedge clk_in);
    chk("reset_state", 64'(pk()), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_in);
      chk($sformatf("vec%0d", i), 64'(pk()), 64'(tbl[i].exp));
      tick = tbl[i].tick; init_req = tbl[i].init; n_last = tbl[i].n;
      lif_spike = tbl[i].spike; aer_ready = tbl[i].ready;
    end

    // Sweep 0..9, spikes on neurons 2 and 7 (writes in cycles 8 and 13).
    sd_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      if (c > 0) begin
        if (aer_valid && aer_ready) pops.push_back(int'(aer_addr));
        if (step_done) begin
          sd_cnt++;
          chk("spk_done_cycle", 64'(c), 64'd16);
        end
      end
      tick = (c == 0); n_last = 10'd9; aer_ready = 1'b1;
      lif_spike = (c == 8 || c == 13);
    end
    chk("spk_pop_count", 64'(pops.size()), 64'd2);
    for (int i = 0; i < pops.size() && i < 2; i++)
      chk($sformatf("spk_pop%0d", i), 64'(pops[i]), (i == 0) ? 64'd2 : 64'd7);
    chk("spk_empty", 64'(aer_valid), 64'd0);
    chk("spk_done_count", 64'(sd_cnt), 64'd1);
    aer_ready = 1'b0; lif_spike = 1'b0;

    // Sweep 0..5 with a tick and an init_req arriving mid-sweep.
    rd_cnt = 0; sd_cnt = 0;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk_in);
      if (c > 0) begin
        rd_cnt += int'(rd_en);
        sd_cnt += int'(step_done);
      end
      if (c == 8)  chk("mid_tick_missed", 64'(tick_missed), 64'd1);
      if (c == 12) chk("mid_step_done", 64'(step_done), 64'd1);
      if (c == 13) chk("mid_init_start", 64'({wr_en, wr_init, wr_addr, tick_missed, rd_en}),
                       64'({1'b1, 1'b1, 10'd0, 1'b0, 1'b0}));
      if (c == 15) chk("mid_init_last", 64'({wr_en, wr_init, wr_addr}), 64'({2'b11, 10'd2}));
      if (c == 16) chk("mid_idle", 64'(busy), 64'd0);
      tick = (c == 0 || c == 3); init_req = (c == 4);
      n_last = (c == 0) ? 10'd5 : 10'd2;
    end
    chk("mid_rd_count", 64'(rd_cnt), 64'd6);
    chk("mid_done_count", 64'(sd_cnt), 64'd1);

    // init_req and tick together in IDLE: INIT wins, tick reported missed.
    @(negedge clk_in);
    tick = 1'b1; init_req = 1'b1; n_last = 10'd0;
    @(negedge clk_in);
    tick = 1'b0; init_req = 1'b0;
    chk("both_init", 64'({wr_en, wr_init, rd_en, tick_missed}), 64'(4'b1101));
    @(negedge clk_in);
    chk("both_after", 64'({busy, tick_missed}), 64'(2'b01));

    // Overflow, then init flushes the FIFO and clears aer_ovf.
    fill("ovfA");
    chk("ovfA_flags", 64'({aer_ovf, aer_valid, aer_addr}), 64'({2'b11, 10'd0}));
    init_req = 1'b1; n_last = 10'd0;
    @(negedge clk_in);
    init_req = 1'b0;
    chk("flush", 64'({aer_valid, aer_ovf, wr_init}), 64'(3'b001));
    @(negedge clk_in);
    chk("flush_idle", 64'(busy), 64'd0);

    // Overflow again, drain: exactly neurons 0..15 in order.
    fill("ovfB");
    chk("ovfB_ovf", 64'(aer_ovf), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovfB_head%0d", i), 64'({aer_valid, aer_addr}), 64'({1'b1, 10'(i)}));
      aer_ready = 1'b1;
      @(negedge clk_in);
    end
    chk("ovfB_empty", 64'(aer_valid), 64'd0);
    aer_ready = 1'b0;

    // Full FIFO, then reset in the middle of a sweep at neuron 4.
    fill("ovfC");
    @(negedge clk_in);
    tick = 1'b1; n_last = 10'd9;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_in);
      tick = 1'b0;
    end
    chk("rst_pre", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd4}));
    reset_n = 1'b0;
    #1;
    chk("rst_outputs", 64'(pk()), 64'd0);
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    tick = 1'b1; n_last = 10'd1;
    @(negedge clk_in);
    tick = 1'b0;
    chk("rst_first", 64'({rd_en, rd_addr, aer_valid}), 64'({1'b1, 10'd0, 1'b0}));
    @(negedge clk_in);
    chk("rst_second", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd1}));
    wait_done("rst_sweep");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
